gamma_table_loader: RTL and testbench

- Writer side of the custom gamma mapper. The gamma LUT stage reads its 256x8 table from this mapper.
- Accepts a custom gamma table as a byte stream from the config/ESP interface and verifies it with a checksum.
- Writes the table into the inactive bank of an external double-buffered mapper RAM.
- Swaps banks only on a vsync boundary, so the video path never samples a half-loaded table.

---
 rtl/gamma_table_loader.sv | 171 +++++++++++++++++
 tb/tb_gamma_table_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gamma_table_loader.sv
// Writer side of the double-buffered gamma mapper: receives a 256-entry table as a byte
// stream, verifies its additive checksum, fills the inactive bank and swaps on vsync.
module gamma_table_loader #(
  parameter int TABLE_SIZE = 256,
  parameter int TIMEOUT    = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       vsync,
  output logic       mapper_wr_en,
  output logic       mapper_wr_bank,
  output logic [7:0] mapper_wr_addr,
  output logic [7:0] mapper_wr_data,
  output logic       active_bank,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    LAST_ADDR  = 8'(TABLE_SIZE - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    CHECK     = 2'd2,
    WAIT_SWAP = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    addr_r, addr_s;
  logic [7:0]    sum_r, sum_s;
  logic [TW-1:0] timer_r, timer_s;
  logic          error_r, error_s;
  logic          bank_r, bank_s;
  logic          done_r, done_s;
  logic          wr_en_r, wr_en_s;
  logic          wr_bank_r, wr_bank_s;
  logic [7:0]    wr_addr_r, wr_addr_s;
  logic [7:0]    wr_data_r, wr_data_s;
  logic          ready_s;
  logic          accept_s;

  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    add_mod256 = a + b;
  endfunction

  assign ready_s  = (state_r == LOAD) || (state_r == CHECK);
  assign accept_s = in_valid && ready_s;

  // Next-state, datapath and output decode; load_start overrides everything else.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    sum_s     = sum_r;
    timer_s   = timer_r;
    error_s   = error_r;
    bank_s    = bank_r;
    done_s    = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    if (load_start) begin
      state_s = LOAD;
      addr_s  = 8'd0;
      sum_s   = 8'd0;
      timer_s = {TW{1'b0}};
      error_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        LOAD: begin
          if (accept_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addr_r;
            wr_data_s = in_data;
            sum_s     = add_mod256(sum_r, in_data);
            timer_s   = {TW{1'b0}};
            if (addr_r == LAST_ADDR) begin
              state_s = CHECK;
            end else begin
              addr_s = addr_r + 8'd1;
            end
          end else if (timer_r == TIMER_LAST) begin
            error_s = 1'b1;
            state_s = IDLE;
          end else begin
            timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        CHECK: begin
          if (accept_s) begin
            timer_s = {TW{1'b0}};
            if (add_mod256(sum_r, in_data) == 8'd0) begin
              state_s = WAIT_SWAP;
            end else begin
              error_s = 1'b1;
              state_s = IDLE;
            end
          end else if (timer_r == TIMER_LAST) begin
            error_s = 1'b1;
            state_s = IDLE;
          end else begin
            timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        WAIT_SWAP: begin
          if (vsync) begin
            bank_s  = ~bank_r;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = WAIT_SWAP;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
    // The write bank tracks the inactive bank, including right after a swap.
    wr_bank_s = ~bank_s;
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      addr_r    <= 8'd0;
      sum_r     <= 8'd0;
      timer_r   <= {TW{1'b0}};
      error_r   <= 1'b0;
      bank_r    <= 1'b0;
      done_r    <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_bank_r <= 1'b0;
      wr_addr_r <= 8'd0;
      wr_data_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      sum_r     <= sum_s;
      timer_r   <= timer_s;
      error_r   <= error_s;
      bank_r    <= bank_s;
      done_r    <= done_s;
      wr_en_r   <= wr_en_s;
      wr_bank_r <= wr_bank_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
    end
  end

  assign in_ready       = ready_s;
  assign busy           = (state_r != IDLE);
  assign done           = done_r;
  assign error          = error_r;
  assign active_bank    = bank_r;
  assign mapper_wr_en   = wr_en_r;
  assign mapper_wr_bank = wr_bank_r;
  assign mapper_wr_addr = wr_addr_r;
  assign mapper_wr_data = wr_data_r;

endmodule

// File: tb/tb_gamma_table_loader.sv
// Directed bench for gamma_table_loader: nominal load, bad checksum, stalled stream,
// timeout, mid-load restart, load_start/vsync priority and reset during WAIT_SWAP.
module tb_gamma_table_loader;

  logic       clock = 1'b0;
  logic       reset, load_start, in_valid, vsync;
  logic [7:0] in_data;
  logic       in_ready, mapper_wr_en, mapper_wr_bank, active_bank, busy, done, error;
  logic [7:0] mapper_wr_addr, mapper_wr_data;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_active = 1'b0;

  always #5 clock = ~clock;

  gamma_table_loader #(.TABLE_SIZE(256), .TIMEOUT(100)) dut (
    .clock(clock), .reset(reset), .load_start(load_start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .vsync(vsync),
    .mapper_wr_en(mapper_wr_en), .mapper_wr_bank(mapper_wr_bank),
    .mapper_wr_addr(mapper_wr_addr), .mapper_wr_data(mapper_wr_data),
    .active_bank(active_bank), .busy(busy), .done(done), .error(error)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_wr_en"}, mapper_wr_en, 32'd0);
    check_val({tag, "_wr_bank"}, mapper_wr_bank, 32'd0);
    check_val({tag, "_wr_addr"}, mapper_wr_addr, 32'd0);
    check_val({tag, "_wr_data"}, mapper_wr_data, 32'd0);
    check_val({tag, "_active"}, active_bank, 32'd0);
    check_val({tag, "_busy"}, busy, 32'd0);
    check_val({tag, "_done"}, done, 32'd0);
    check_val({tag, "_error"}, error, 32'd0);
    check_val({tag, "_ready"}, in_ready, 32'd0);
  endtask

  // with_byte presents a data byte alongside load_start; it must be discarded.
  task automatic start_session(input logic with_byte);
    load_start = 1'b1;
    in_valid   = with_byte;
    in_data    = 8'hAA;
    step();
    load_start = 1'b0;
    in_valid   = 1'b0;
    check_val("start_busy", busy, 32'd1);
    check_val("start_error", error, 32'd0);
    check_val("start_ready", in_ready, 32'd1);
    check_val("start_no_wr", mapper_wr_en, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_data, input logic [7:0] a);
    check_val("ready", in_ready, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    if (is_data) begin
      check_val("wr_en", mapper_wr_en, 32'd1);
      check_val("wr_addr", mapper_wr_addr, {24'd0, a});
      check_val("wr_data", mapper_wr_data, {24'd0, b});
      check_val("wr_bank", mapper_wr_bank, {31'd0, ~exp_active});
    end else begin
      check_val("chk_no_wr", mapper_wr_en, 32'd0);
    end
  endtask

  task automatic idle_cycle();
    step();
    check_val("stall_no_wr", mapper_wr_en, 32'd0);
  endtask

  task automatic send_table(input int n, input logic stall);
    for (int i = 0; i < n; i++) begin
      send_byte(8'(255 - i), 1'b1, 8'(i));
      if (stall) idle_cycle();
    end
  endtask

  task automatic do_swap();
    vsync = 1'b1;
    check_val("pre_swap_bank", active_bank, {31'd0, exp_active});
    step();
    vsync = 1'b0;
    exp_active = ~exp_active;
    check_val("swap_bank", active_bank, {31'd0, exp_active});
    check_val("swap_done", done, 32'd1);
    check_val("swap_busy", busy, 32'd0);
    check_val("swap_error", error, 32'd0);
    step();
    check_val("done_pulse", done, 32'd0);
    check_val("post_swap_bank", active_bank, {31'd0, exp_active});
  endtask

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    vsync      = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    step();
    check_val("idle_busy", busy, 32'd0);

    // Bad checksum: table sums to 0x80, so 0x81 fails.
    start_session(1'b0);
    send_table(256, 1'b0);
    send_byte(8'h81, 1'b0, 8'd0);
    check_val("bad_error", error, 32'd1);
    check_val("bad_busy", busy, 32'd0);
    check_val("bad_bank", active_bank, 32'd0);
    check_val("bad_done", done, 32'd0);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    check_val("idle_vsync_bank", active_bank, 32'd0);
    check_val("idle_vsync_done", done, 32'd0);

    // Nominal load, vsync after 10 cycles.
    start_session(1'b0);
    send_table(256, 1'b0);
    send_byte(8'h80, 1'b0, 8'd0);
    check_val("wait_busy", busy, 32'd1);
    check_val("wait_ready", in_ready, 32'd0);
    check_val("wait_error", error, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      check_val("wait_bank", active_bank, {31'd0, exp_active});
      check_val("wait_done", done, 32'd0);
    end
    do_swap();

    // Stalled stream: valid toggles every cycle, writes go to bank 0.
    start_session(1'b0);
    send_table(256, 1'b1);
    send_byte(8'h80, 1'b0, 8'd0);
    repeat (3) step();
    do_swap();

    // Timeout: 40 bytes then silence; aborts exactly 100 cycles after last accept.
    start_session(1'b0);
    send_table(40, 1'b0);
    repeat (99) step();
    check_val("to_busy_99", busy, 32'd1);
    check_val("to_error_99", error, 32'd0);
    step();
    check_val("to_busy_100", busy, 32'd0);
    check_val("to_error_100", error, 32'd1);
    check_val("to_bank", active_bank, {31'd0, exp_active});

    // Restart mid-load; the byte arriving with load_start is dropped.
    start_session(1'b0);
    send_table(100, 1'b0);
    start_session(1'b1);
    send_table(256, 1'b0);
    send_byte(8'h80, 1'b0, 8'd0);
    do_swap();

    // load_start and vsync together in WAIT_SWAP: no swap, back in LOAD.
    start_session(1'b0);
    send_table(256, 1'b0);
    send_byte(8'h80, 1'b0, 8'd0);
    step();
    load_start = 1'b1;
    vsync      = 1'b1;
    step();
    load_start = 1'b0;
    vsync      = 1'b0;
    check_val("prio_bank", active_bank, {31'd0, exp_active});
    check_val("prio_done", done, 32'd0);
    check_val("prio_busy", busy, 32'd1);
    check_val("prio_ready", in_ready, 32'd1);

    // Reset while waiting to swap with active_bank=1.
    send_table(256, 1'b0);
    send_byte(8'h80, 1'b0, 8'd0);
    check_val("rst_pre_busy", busy, 32'd1);
    check_val("rst_pre_bank", active_bank, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
